// File: rtl/mkio_rt_scheduler_if.sv
// ---------------------------------------------------------------------------
// mkio_rt_scheduler_if
//
// Word-level bus between the MKIO decoder/encoder pair and the remote-terminal
// scheduler.
//
//   rx_done  : one-cycle strobe, a word has been received
//   rx_data  : received word
//   rx_cd    : 1 = command sync, 0 = data sync
//   p_error  : parity error on the current received word
//   tx_data  : word handed to the shared encoder
//   tx_cd    : sync type for the encoder (0 = data/status sync)
//   tx_ready : encoder request, word on tx_data is valid
//   tx_busy  : encoder still shifting out a word
//
// Modports: master = decoder/encoder side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface mkio_rt_scheduler_if;
    logic        rx_done;
    logic [15:0] rx_data;
    logic        rx_cd;
    logic        p_error;
    logic [15:0] tx_data;
    logic        tx_cd;
    logic        tx_ready;
    logic        tx_busy;

    modport master (
        output rx_done, rx_data, rx_cd, p_error, tx_busy,
        input  tx_data, tx_cd, tx_ready
    );

    modport slave (
        input  rx_done, rx_data, rx_cd, p_error, tx_busy,
        output tx_data, tx_cd, tx_ready
    );
endinterface

// File: rtl/mkio_rt_scheduler.sv
// ---------------------------------------------------------------------------
// mkio_rt_scheduler
//
// Remote-terminal command scheduler. Decodes a received command word, starts
// the device mapped to its subaddress, waits (bounded) for that device's
// status word and hands it to the shared encoder. Unmapped subaddresses are
// answered with the scheduler's own status word (message-error bit set).
//
// Parameters:
//   RT_ADDRESS : own remote-terminal address
//   NUM_DEV    : devices on subaddresses 1..NUM_DEV (1..8)
//   TIMEOUT    : clk cycles a dispatched device has to answer
//
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   bus          : rx/tx word bus (slave modport of mkio_rt_scheduler_if)
//   dev_start    : one-hot start pulse to the selected device
//   dev_busy     : per-device busy flags
//   dev_tx_ready : per-device status-word request
//   dev_tx_data  : per-device status word, device k at [16k+15:16k]
//   active       : transaction in progress
//   cmd_cnt      : accepted commands (saturating)
//   err_cnt      : error events (saturating)
//
// Optional feature: define MKIO_BROADCAST_EN to accept address 31 as a
// broadcast (device started, no status word sent). Without it address 31 is
// an ordinary address mismatch.
// ---------------------------------------------------------------------------
module mkio_rt_scheduler #(
    parameter logic [4:0]  RT_ADDRESS = 5'd1,
    parameter int          NUM_DEV    = 4,
    parameter logic [15:0] TIMEOUT    = 16'd2000
) (
    input  logic                   clk,
    input  logic                   reset,
    mkio_rt_scheduler_if.slave     bus,
    output logic [NUM_DEV-1:0]     dev_start,
    input  logic [NUM_DEV-1:0]     dev_busy,
    input  logic [NUM_DEV-1:0]     dev_tx_ready,
    input  logic [16*NUM_DEV-1:0]  dev_tx_data,
    output logic                   active,
    output logic [7:0]             cmd_cnt,
    output logic [7:0]             err_cnt
);

    localparam int GW = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
    localparam logic [15:0] STATUS_WORD = {RT_ADDRESS, 1'b1, 10'd0};

    typedef enum logic [2:0] {
        IDLE, DECODE, DISPATCH, WAIT_DEV, RESP, TX_WAIT
    } state_t;

    state_t         state_q, state_d;

    logic [4:0]     addr_q;
    logic [4:0]     sa_q;
    logic           perr_q;
    logic [GW-1:0]  g_q;
    logic           has_dev_q;     // a device was dispatched this transaction
    logic [15:0]    timer_q;
    logic [15:0]    resp_q;
    logic [1:0]     resp_cnt_q;

    // FSM control strobes
    logic           load_cmd;
    logic           load_g;
    logic           clr_timer;
    logic           load_status;
    logic           capture;
    logic           cmd_inc;
    logic           fsm_err;

    logic           rx_cmd;
    logic           stray_err;
    logic           sa_mapped;
    logic [GW-1:0]  sa_g;
    logic           is_bcast;
    logic           timeout_hit;
    logic [8:0]     err_sum;

    assign rx_cmd      = bus.rx_done && bus.rx_cd;
    // A command word arriving mid-transaction is dropped and counted.
    assign stray_err   = rx_cmd && (state_q != IDLE);
    assign sa_mapped   = (sa_q != 5'd0) && (int'(sa_q) <= NUM_DEV);
    assign sa_g        = GW'(sa_q - 5'd1);
    assign timeout_hit = (timer_q == TIMEOUT - 16'd1);
    assign err_sum     = {1'b0, err_cnt} + 9'(fsm_err) + 9'(stray_err);

`ifdef MKIO_BROADCAST_EN
    assign is_bcast = (addr_q == 5'd31);
`else
    assign is_bcast = 1'b0;
`endif

    assign active       = (state_q != IDLE);
    assign bus.tx_ready = (state_q == RESP);
    assign bus.tx_cd    = 1'b0;
    assign bus.tx_data  = resp_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            // NOTE: non-blocking assignment so every register in this edge
            // sees the pre-edge values, independent of block ordering.
            state_q <= state_d;
        end
    end

    // Next-state and control decode
    always_comb begin
        // NOTE: everything written here gets a default first; a path that
        // skipped an assignment would otherwise infer a latch.
        state_d     = state_q;
        load_cmd    = 1'b0;
        load_g      = 1'b0;
        clr_timer   = 1'b0;
        load_status = 1'b0;
        capture     = 1'b0;
        cmd_inc     = 1'b0;
        fsm_err     = 1'b0;
        dev_start   = '0;

        case (state_q)
            IDLE: begin
                if (rx_cmd) begin
                    load_cmd = 1'b1;
                    state_d  = DECODE;
                end
            end

            DECODE: begin
                if (perr_q) begin
                    fsm_err = 1'b1;
                    state_d = IDLE;
                end else if (addr_q == RT_ADDRESS) begin
                    cmd_inc = 1'b1;
                    if (sa_mapped) begin
                        state_d = DISPATCH;
                    end else begin
                        load_status = 1'b1;
                        state_d     = RESP;
                    end
                end else if (is_bcast) begin
                    // Broadcast never answers, so an unmapped SA just ends.
                    cmd_inc = 1'b1;
                    state_d = sa_mapped ? DISPATCH : IDLE;
                end else begin
                    state_d = IDLE;
                end
            end

            DISPATCH: begin
                dev_start[sa_g] = 1'b1;
                load_g          = 1'b1;
                clr_timer       = 1'b1;
                state_d         = WAIT_DEV;
            end

            WAIT_DEV: begin
                // Only the granted device is looked at; a response in the
                // same cycle as the timeout wins.
                if (!is_bcast && dev_tx_ready[g_q]) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else if (is_bcast && !dev_busy[g_q]) begin
                    state_d = TX_WAIT;
                end else if (timeout_hit) begin
                    fsm_err = 1'b1;
                    state_d = IDLE;
                end
            end

            RESP: begin
                if (resp_cnt_q == 2'd2) begin
                    state_d = TX_WAIT;
                end
            end

            TX_WAIT: begin
                if (!bus.tx_busy && !(has_dev_q && dev_busy[g_q])) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Datapath and counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            sa_q       <= '0;
            perr_q     <= 1'b0;
            g_q        <= '0;
            has_dev_q  <= 1'b0;
            timer_q    <= '0;
            resp_q     <= '0;
            resp_cnt_q <= '0;
            cmd_cnt    <= '0;
            err_cnt    <= '0;
        end else begin
            if (load_cmd) begin
                addr_q    <= bus.rx_data[15:11];
                sa_q      <= bus.rx_data[9:5];
                perr_q    <= bus.p_error;
                has_dev_q <= 1'b0;
            end

            if (load_g) begin
                g_q       <= sa_g;
                has_dev_q <= 1'b1;
            end

            if (clr_timer) begin
                timer_q <= '0;
            end else if (state_q == WAIT_DEV) begin
                timer_q <= timer_q + 16'd1;
            end

            if (load_status) begin
                resp_q <= STATUS_WORD;
            end else if (capture) begin
                resp_q <= dev_tx_data[{g_q, 4'b0000} +: 16];
            end

            resp_cnt_q <= (state_q == RESP) ? resp_cnt_q + 2'd1 : 2'd0;

            if (cmd_inc && (cmd_cnt != 8'hFF)) begin
                cmd_cnt <= cmd_cnt + 8'd1;
            end

            // Two error sources can land on the same edge.
            err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end

endmodule

// File: tb/tb_mkio_rt_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mkio_rt_scheduler
//
// Self-checking bench for mkio_rt_scheduler (RT_ADDRESS=1, NUM_DEV=4,
// TIMEOUT=20). A table of single-command transactions is applied through a
// small device model, followed by hand-written sequences for stray commands,
// TX_WAIT holding, reset during RESP and counter saturation.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mkio_rt_scheduler;

    localparam logic [63:0] NOISE = {16'hEE03, 16'hEE02, 16'hEE01, 16'hEE00};

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  dev_start;
    logic [3:0]  dev_busy;
    logic [3:0]  dev_tx_ready;
    logic [63:0] dev_tx_data;
    logic        active;
    logic [7:0]  cmd_cnt;
    logic [7:0]  err_cnt;

    mkio_rt_scheduler_if bus();

    mkio_rt_scheduler #(
        .RT_ADDRESS (5'd1),
        .NUM_DEV    (4),
        .TIMEOUT    (16'd20)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .dev_start    (dev_start),
        .dev_busy     (dev_busy),
        .dev_tx_ready (dev_tx_ready),
        .dev_tx_data  (dev_tx_data),
        .active       (active),
        .cmd_cnt      (cmd_cnt),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] cmd;
        logic        perr;
        int          tgt;        // device the bench model answers for
        logic        respond;
        logic [15:0] word;
        logic [3:0]  exp_start;
        int          exp_rdy;    // tx_ready cycles
        logic [15:0] exp_word;
        int          dcmd;
        int          derr;
        int          exp_end;    // cycle count until active drops
    } vec_t;

    typedef struct {
        logic [3:0]  start_or;
        int          start_cycles;
        int          start_lat;
        int          rdy_cycles;
        logic [15:0] rdy_word;
        logic        cd_bad;
        int          end_cyc;
    } res_t;

    int total = 0;
    int bad   = 0;
    int exp_cmd = 0;
    int exp_err = 0;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i, input string name, input logic [15:0] cmd, input logic perr,
                           input int tgt, input logic respond, input logic [15:0] word,
                           input logic [3:0] exp_start, input int exp_rdy, input logic [15:0] exp_word,
                           input int dcmd, input int derr, input int exp_end);
        vecs[i].name = name;       vecs[i].cmd = cmd;           vecs[i].perr = perr;
        vecs[i].tgt = tgt;         vecs[i].respond = respond;   vecs[i].word = word;
        vecs[i].exp_start = exp_start; vecs[i].exp_rdy = exp_rdy; vecs[i].exp_word = exp_word;
        vecs[i].dcmd = dcmd;       vecs[i].derr = derr;         vecs[i].exp_end = exp_end;
    endtask

    // Apply one command and follow it until active drops (bounded).
    task automatic run_cmd(input vec_t v, output res_t r);
        int n;
        int ready_at;
        r.start_or = '0; r.start_cycles = 0; r.start_lat = -1; r.rdy_cycles = 0;
        r.rdy_word = '0; r.cd_bad = 1'b0; r.end_cyc = -1;
        ready_at = -1;
        dev_tx_data  = NOISE;
        dev_tx_ready = ~(4'b0001 << v.tgt);   // every other device keeps requesting
        bus.rx_data  = v.cmd;
        bus.rx_cd    = 1'b1;
        bus.p_error  = v.perr;
        bus.rx_done  = 1'b1;
        step();
        n = 1;
        bus.rx_done = 1'b0;
        bus.p_error = 1'b0;
        while (n < 200) begin
            if (dev_start != 4'b0000) begin
                r.start_or = r.start_or | dev_start;
                r.start_cycles++;
                if (r.start_lat < 0) r.start_lat = n;
                if (v.respond) ready_at = n + 2;
            end
            if (bus.tx_ready) begin
                r.rdy_cycles++;
                r.rdy_word = bus.tx_data;
                if (bus.tx_cd !== 1'b0) r.cd_bad = 1'b1;
            end
            if (n == ready_at) begin
                dev_tx_ready[v.tgt]          = 1'b1;
                dev_tx_data[16*v.tgt +: 16] = v.word;
            end
            if (!active) begin
                r.end_cyc = n;
                break;
            end
            step();
            n++;
        end
        dev_tx_ready = 4'b0000;
        dev_tx_data  = NOISE;
    endtask

    task automatic bump_cmd(input int d);
        exp_cmd = (exp_cmd + d > 255) ? 255 : exp_cmd + d;
    endtask

    task automatic bump_err(input int d);
        exp_err = (exp_err + d > 255) ? 255 : exp_err + d;
    endtask

    initial begin
        res_t r;
        int   k;
        logic seen;

        reset        = 1'b1;
        bus.rx_done  = 1'b0;
        bus.rx_data  = '0;
        bus.rx_cd    = 1'b0;
        bus.p_error  = 1'b0;
        bus.tx_busy  = 1'b0;
        dev_busy     = '0;
        dev_tx_ready = '0;
        dev_tx_data  = NOISE;

        //            name          cmd       perr tgt rsp word      start    rdy word      dc de end
        set_vec(0,  "sa2_dev1",   16'h0843, 1'b0, 1, 1'b1, 16'h0800, 4'b0010, 3, 16'h0800, 1, 0, 9);
        set_vec(1,  "sa6_unmap",  16'h08C1, 1'b0, 0, 1'b0, 16'h0000, 4'b0000, 3, 16'h0C00, 1, 0, 6);
        set_vec(2,  "parity",     16'h0843, 1'b1, 1, 1'b0, 16'h0000, 4'b0000, 0, 16'h0000, 0, 1, 2);
        set_vec(3,  "addr_miss",  16'h1043, 1'b0, 1, 1'b0, 16'h0000, 4'b0000, 0, 16'h0000, 0, 0, 2);
`ifdef MKIO_BROADCAST_EN
        set_vec(4,  "bcast",      16'hF843, 1'b0, 1, 1'b1, 16'h0000, 4'b0010, 0, 16'h0000, 1, 0, 5);
`else
        set_vec(4,  "addr31",     16'hF843, 1'b0, 1, 1'b1, 16'h0000, 4'b0000, 0, 16'h0000, 0, 0, 2);
`endif
        set_vec(5,  "sa1_dev0",   16'h0C20, 1'b0, 0, 1'b1, 16'h0801, 4'b0001, 3, 16'h0801, 1, 0, 9);
        set_vec(6,  "sa4_dev3",   16'h0885, 1'b0, 3, 1'b1, 16'h0810, 4'b1000, 3, 16'h0810, 1, 0, 9);
        set_vec(7,  "sa0_unmap",  16'h0802, 1'b0, 0, 1'b0, 16'h0000, 4'b0000, 3, 16'h0C00, 1, 0, 6);
        set_vec(8,  "sa5_unmap",  16'h08A0, 1'b0, 0, 1'b0, 16'h0000, 4'b0000, 3, 16'h0C00, 1, 0, 6);
        set_vec(9,  "sa3_dev2",   16'h0C7F, 1'b0, 2, 1'b1, 16'hABCD, 4'b0100, 3, 16'hABCD, 1, 0, 9);
        // Device never answers: WAIT_DEV from cycle 3 for 20 cycles.
        set_vec(10, "timeout",    16'h0843, 1'b0, 1, 1'b0, 16'h0000, 4'b0010, 0, 16'h0000, 1, 1, 23);

        step(); step(); step();
        reset = 1'b0;
        step();

        // Reset state
        check("rst_active",   active,       1'b0);
        check("rst_tx_ready", bus.tx_ready, 1'b0);
        check("rst_dev_start", dev_start,   4'b0000);
        check("rst_tx_data",  bus.tx_data,  16'h0000);
        check("rst_tx_cd",    bus.tx_cd,    1'b0);
        check("rst_cmd_cnt",  cmd_cnt,      8'd0);
        check("rst_err_cnt",  err_cnt,      8'd0);

        // Table-driven transactions
        foreach (vecs[i]) begin
            run_cmd(vecs[i], r);
            bump_cmd(vecs[i].dcmd);
            bump_err(vecs[i].derr);
            check({vecs[i].name, "_start"},     r.start_or,     vecs[i].exp_start);
            check({vecs[i].name, "_start_len"}, r.start_cycles, (vecs[i].exp_start != 0) ? 1 : 0);
            check({vecs[i].name, "_start_lat"}, r.start_lat,    (vecs[i].exp_start != 0) ? 2 : -1);
            check({vecs[i].name, "_rdy_len"},   r.rdy_cycles,   vecs[i].exp_rdy);
            if (vecs[i].exp_rdy > 0)
                check({vecs[i].name, "_tx_data"}, r.rdy_word, vecs[i].exp_word);
            check({vecs[i].name, "_tx_cd"},     r.cd_bad,       1'b0);
            check({vecs[i].name, "_end"},       r.end_cyc,      vecs[i].exp_end);
            check({vecs[i].name, "_cmd_cnt"},   cmd_cnt,        exp_cmd);
            check({vecs[i].name, "_err_cnt"},   err_cnt,        exp_err);
        end

        // Stray commands while busy, then TX_WAIT held by dev_busy and tx_busy
        dev_tx_data  = NOISE;
        dev_tx_ready = 4'b1101;
        dev_busy     = 4'b0010;
        bus.rx_data  = 16'h0843; bus.rx_cd = 1'b1; bus.rx_done = 1'b1;
        step();
        bus.rx_done = 1'b0;
        step(); step();                       // now in WAIT_DEV
        bus.rx_data = 16'h1234; bus.rx_cd = 1'b1; bus.rx_done = 1'b1;
        step();
        bus.rx_cd = 1'b0;                     // data word: not an error
        step();
        bus.rx_done = 1'b0;
        bump_cmd(1);
        bump_err(1);
        check("stray_active",  active,  1'b1);
        check("stray_err_cnt", err_cnt, exp_err);
        dev_tx_data[31:16] = 16'h0822;
        dev_tx_ready[1]    = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.tx_ready) seen = 1'b1; else step();
        end
        check("stray_rdy_seen", seen, 1'b1);
        check("stray_tx_data",  bus.tx_data, 16'h0822);
        bus.tx_busy  = 1'b1;
        dev_tx_ready = 4'b0000;
        k = 0;
        while (bus.tx_ready && k < 10) begin step(); k++; end
        check("stray_rdy_drop", bus.tx_ready, 1'b0);
        step(); step(); step();
        check("txwait_hold_dev", active, 1'b1);
        dev_busy = 4'b0000;
        step();
        check("txwait_hold_enc", active, 1'b1);
        bus.tx_busy = 1'b0;
        step();
        check("txwait_release", active, 1'b0);
        check("stray_cmd_cnt",  cmd_cnt, exp_cmd);

        // Reset in the middle of RESP
        dev_tx_data[31:16] = 16'h0800;
        dev_tx_ready       = 4'b0010;
        bus.rx_data = 16'h0843; bus.rx_cd = 1'b1; bus.rx_done = 1'b1;
        step();
        bus.rx_done = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.tx_ready) seen = 1'b1; else step();
        end
        check("rstresp_in_resp", seen, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("rstresp_tx_ready", bus.tx_ready, 1'b0);
        check("rstresp_active",   active,       1'b0);
        check("rstresp_cmd_cnt",  cmd_cnt,      8'd0);
        exp_cmd = 0;
        exp_err = 0;
        dev_tx_ready = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
        step();
        run_cmd(vecs[0], r);
        bump_cmd(1);
        check("after_rst_start",   r.start_or,   4'b0010);
        check("after_rst_rdy_len", r.rdy_cycles, 3);
        check("after_rst_tx_data", r.rdy_word,   16'h0800);
        check("after_rst_cmd_cnt", cmd_cnt,      8'd1);

        // Saturation of both counters
        for (int i = 0; i < 260; i++) begin
            bus.rx_data = 16'h0843; bus.rx_cd = 1'b1; bus.p_error = 1'b1; bus.rx_done = 1'b1;
            step();
            bus.rx_done = 1'b0; bus.p_error = 1'b0;
            step();
            bump_err(1);
        end
        check("err_sat", err_cnt, 8'hFF);
        for (int i = 0; i < 260; i++) begin
            bus.rx_data = 16'h08C1; bus.rx_cd = 1'b1; bus.rx_done = 1'b1;
            step();
            bus.rx_done = 1'b0;
            k = 0;
            while (active && k < 20) begin step(); k++; end
            bump_cmd(1);
        end
        check("cmd_sat", cmd_cnt, 8'hFF);
        check("sat_err_hold", err_cnt, exp_err);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mkio_rt_scheduler.md
MKIO_RT_SCHEDULER -- requirements
Module: mkio_rt_scheduler

Interface
REQ-001 SHALL have parameter RT_ADDRESS, default 5'd1, own remote-terminal address.
REQ-002 SHALL have parameter NUM_DEV, default 4 (range 1..8), devices mapped to subaddresses 1..NUM_DEV.
REQ-003 SHALL have parameter TIMEOUT, default 16'd2000, clk cycles allowed from dispatch to device response.
REQ-004 SHALL have ports: clk in 1 clock; reset in 1 reset, asynchronous, active-high.
REQ-005 SHALL have ports: rx_done in 1 word-received strobe; rx_data in 16 received word; rx_cd in 1 1=command sync, 0=data sync; p_error in 1 parity error on current word.
REQ-006 SHALL have ports: dev_start out NUM_DEV one-hot start pulses; dev_busy in NUM_DEV device busy flags; dev_tx_ready in NUM_DEV device status-word requests; dev_tx_data in 16*NUM_DEV device status words, device k at bits [16k+15:16k].
REQ-007 SHALL have ports: tx_data out 16 word to shared encoder; tx_cd out 1 sync type to encoder; tx_ready out 1 encoder request; tx_busy in 1 encoder busy.
REQ-008 SHALL have ports: active out 1 transaction in progress; cmd_cnt out 8 accepted commands; err_cnt out 8 error events.

Function
REQ-009 Command word SHALL be decoded as [15:11] address, [10] T/R, [9:5] subaddress SA, [4:0] word count.
REQ-010 States SHALL be IDLE, DECODE, DISPATCH, WAIT_DEV, RESP, TX_WAIT.
REQ-011 IDLE: on rx_done=1 and rx_cd=1 SHALL register rx_data and p_error and go to DECODE next cycle; other rx_done ignored.
REQ-012 DECODE: p_error=1 -> err_cnt+1, IDLE; address mismatch -> IDLE, no count; else cmd_cnt+1 and DISPATCH if 1<=SA<=NUM_DEV, otherwise RESP with scheduler status word.
REQ-013 DISPATCH: SHALL assert dev_start[SA-1] for exactly one cycle, latch grant index g=SA-1, clear timeout counter, go to WAIT_DEV.
REQ-014 WAIT_DEV: only dev_tx_ready[g] and dev_tx_data[g] SHALL be observed; all other devices' tx requests ignored while active=1.
REQ-015 WAIT_DEV: dev_tx_ready[g]=1 -> capture dev_tx_data[g], go to RESP; timeout counter reaching TIMEOUT -> err_cnt+1, IDLE, no transmission.
REQ-016 RESP: SHALL drive tx_data = captured word, tx_cd=0, tx_ready=1 for exactly 3 cycles, then go to TX_WAIT.
REQ-017 Unmapped SA status word SHALL be {RT_ADDRESS, 1'b1, 10'd0} (message-error bit set).
REQ-018 TX_WAIT: SHALL return to IDLE on first cycle with tx_busy=0 and dev_busy[g]=0.
REQ-019 rx_done with rx_cd=1 in any state other than IDLE SHALL be ignored and increment err_cnt.
REQ-020 cmd_cnt and err_cnt SHALL saturate at 8'hFF; counter increments are independent and may coincide.
REQ-021 active SHALL be 1 in every state except IDLE; tx_ready SHALL be 0 outside RESP; dev_start SHALL be 0 outside DISPATCH.
REQ-022 Total latency rx_done (command) to dev_start pulse SHALL be 2 clk cycles.

Reset
REQ-023 reset=1 SHALL force IDLE from any state within the same edge, aborting any pending response.
REQ-024 Reset values: dev_start=0, tx_data=16'd0, tx_cd=0, tx_ready=0, active=0, cmd_cnt=0, err_cnt=0, timeout counter=0.

Configuration
REQ-025 Macro MKIO_BROADCAST_EN defined: address 5'd31 SHALL be accepted as broadcast; device dispatched as normal, RESP skipped, WAIT_DEV exits to TX_WAIT on dev_busy[g]=0, timeout still applies.
REQ-026 MKIO_BROADCAST_EN undefined: address 5'd31 SHALL be treated as address mismatch.

Verification
REQ-027 Command 16'h0843 (addr 1, SA 2, WC 3), device 1 raises tx_ready with 16'h0800 -> dev_start=4'b0010 one cycle, tx_data=16'h0800 with tx_ready 3 cycles, cmd_cnt=1.
REQ-028 Command 16'h08C1 (SA 6, NUM_DEV=4) -> tx_data=16'h0C00, tx_ready 3 cycles, no dev_start.
REQ-029 Command 16'h0843 with p_error=1 -> no dev_start, err_cnt=1, active back to 0 after 2 cycles.
REQ-030 Command 16'h0843, device never responds -> after TIMEOUT cycles err_cnt=1, IDLE, tx_ready never asserted.
REQ-031 Command 16'hF843 with MKIO_BROADCAST_EN -> dev_start=4'b0010, no tx_ready; without macro -> no dev_start, cmd_cnt=0.
REQ-032 reset asserted during RESP -> tx_ready=0 and active=0 immediately; subsequent 16'h0843 processed normally.
